// File: rtl/agc_pkg.sv
// agc_pkg: shared types and helpers for the AGC servo.
// States, scale limits and a signed clamp.
package agc_pkg;

  localparam int SCALE_BITS = 17;
  localparam int SCALE_MAX  = 131071;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ACCUM  = 3'd3,
    ST_CALC   = 3'd4
  } state_t;

  function automatic logic signed [63:0] clamp_s(
    input logic signed [63:0] v,
    input logic signed [63:0] lo,
    input logic signed [63:0] hi
  );
    logic signed [63:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/agc_servo_stats.sv
// agc_servo_stats: window sample counter plus gt/lt/sum accumulators.
// done fires with the sample that completes the window.
module agc_servo_stats
  import agc_pkg::*;
#(
  parameter int NBITS       = 5,
  parameter int WINDOW_LOG2 = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          en,
  input  logic                          gt,
  input  logic                          lt,
  input  logic signed [NBITS-1:0]       dat,
  output logic [WINDOW_LOG2:0]          gt_cnt,
  output logic [WINDOW_LOG2:0]          lt_cnt,
  output logic signed
    [NBITS+WINDOW_LOG2-1:0]             sum,
  output logic                          done
);

  localparam int SUMW = NBITS + WINDOW_LOG2;

  logic [WINDOW_LOG2-1:0] cnt;

  assign done = en & (&cnt);

  // Accumulate qualified samples; clear wipes a partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      gt_cnt <= '0;
      lt_cnt <= '0;
      sum    <= '0;
    end else if (clr) begin
      cnt    <= '0;
      gt_cnt <= '0;
      lt_cnt <= '0;
      sum    <= '0;
    end else if (en) begin
      cnt    <= cnt + WINDOW_LOG2'(1);
      gt_cnt <= gt_cnt + (WINDOW_LOG2+1)'(gt);
      lt_cnt <= lt_cnt + (WINDOW_LOG2+1)'(lt);
      sum    <= sum + SUMW'(dat);
    end
  end

endmodule

// File: rtl/agc_servo.sv
// agc_servo: closed-loop scale/offset servo for one AGC DSP slice.
// Optional window statistics ports under AGC_SERVO_STATS_EN.
module agc_servo
  import agc_pkg::*;
#(
  parameter int NBITS        = 5,
  parameter int OFFSET_BITS  = 12,
  parameter int WINDOW_LOG2  = 16,
  parameter int GT_TARGET    = 2048,
  parameter int SCALE_SHIFT  = 4,
  parameter int OFFSET_SHIFT = 10,
  parameter int SCALE_INIT   = 4096,
  parameter int SCALE_MIN    = 64,
  parameter int SETTLE       = 8
) (
  input  logic                          clk_i,
  input  logic                          aresetn_i,
  input  logic                          en_i,
  input  logic                          valid_i,
  input  logic signed [NBITS-1:0]       dat_i,
  input  logic                          gt_i,
  input  logic                          lt_i,
  output logic [SCALE_BITS-1:0]         scale_o,
  output logic signed
    [OFFSET_BITS-1:0]                   offset_o,
  output logic                          ce_scale_o,
  output logic                          ce_offset_o,
  output logic                          apply_o,
  output logic                          busy_o
`ifdef AGC_SERVO_STATS_EN
  ,
  output logic [WINDOW_LOG2:0]          stat_gt_o,
  output logic [WINDOW_LOG2:0]          stat_lt_o,
  output logic signed
    [NBITS+WINDOW_LOG2-1:0]             stat_sum_o,
  output logic                          stat_valid_o
`endif
);

  localparam int W    = WINDOW_LOG2;
  localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SUMW = NBITS + W;

  localparam logic signed [63:0] OFF_HI =
    (64'sd1 <<< (OFFSET_BITS-1)) - 64'sd1;
  localparam logic signed [63:0] OFF_LO =
    -(64'sd1 <<< (OFFSET_BITS-1));
  localparam logic signed [63:0] SC_LO = 64'(SCALE_MIN);
  localparam logic signed [63:0] SC_HI = 64'(SCALE_MAX);

  state_t state, state_n;
  logic   armed;

  logic [SW-1:0] settle_cnt;
  logic          settle_last;

  logic                   acc_en, acc_clr, done;
  logic [W:0]             gt_cnt, lt_cnt;
  logic signed [SUMW-1:0] sum;

  logic signed [63:0] gt_d, sc_t, sum_d, of_t;
  logic [SCALE_BITS-1:0]         scale_n;
  logic signed [OFFSET_BITS-1:0] offset_n;

  assign settle_last = (settle_cnt == SW'(SETTLE-1));

  assign acc_en  = (state == ST_ACCUM) & en_i & valid_i;
  assign acc_clr = ((state != ST_ACCUM) && (state != ST_CALC))
                 || ((state == ST_ACCUM) && !en_i);

  agc_servo_stats #(
    .NBITS       (NBITS),
    .WINDOW_LOG2 (W)
  ) u_stats (
    .clk    (clk_i),
    .rst_n  (aresetn_i),
    .clr    (acc_clr),
    .en     (acc_en),
    .gt     (gt_i),
    .lt     (lt_i),
    .dat    (dat_i),
    .gt_cnt (gt_cnt),
    .lt_cnt (lt_cnt),
    .sum    (sum),
    .done   (done)
  );

  // Sequence: push values, apply, wait out the DSP pipe, measure.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_LOAD:   if (armed) state_n = ST_APPLY;
      ST_APPLY:  state_n = ST_SETTLE;
      ST_SETTLE: if (valid_i && settle_last) state_n = ST_ACCUM;
      ST_ACCUM:  if (done) state_n = ST_CALC;
      ST_CALC:   state_n = ST_LOAD;
      default:   state_n = ST_LOAD;
    endcase
  end

  // State register; armed keeps strobes low while reset is held.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state <= ST_LOAD;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      armed <= 1'b1;
    end
  end

  // Count valid samples discarded after each apply.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      settle_cnt <= '0;
    end else if (state != ST_SETTLE) begin
      settle_cnt <= '0;
    end else if (valid_i) begin
      settle_cnt <= settle_last ? '0 : settle_cnt + SW'(1);
    end
  end

  // Correction arithmetic, wide signed to avoid any overflow.
  always_comb begin
    gt_d  = 64'($signed({1'b0, gt_cnt})) - 64'(GT_TARGET);
    sc_t  = 64'($signed({1'b0, scale_o}))
          - (gt_d >>> SCALE_SHIFT);
    sum_d = 64'(sum);
    of_t  = 64'(offset_o) - (sum_d >>> OFFSET_SHIFT);
    scale_n  = SCALE_BITS'(clamp_s(sc_t, SC_LO, SC_HI));
    offset_n = OFFSET_BITS'(clamp_s(of_t, OFF_LO, OFF_HI));
  end

  // Scale/offset registers update once per window in CALC.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      scale_o  <= SCALE_BITS'(SCALE_INIT);
      offset_o <= '0;
    end else if (state == ST_CALC) begin
      scale_o  <= scale_n;
      offset_o <= offset_n;
    end
  end

  assign ce_scale_o  = (state == ST_LOAD) & armed;
  assign ce_offset_o = (state == ST_LOAD) & armed;
  assign apply_o     = (state == ST_APPLY);
  assign busy_o      = (state != ST_ACCUM);

`ifdef AGC_SERVO_STATS_EN
  // Latch the finished window's statistics alongside the update.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      stat_gt_o    <= '0;
      stat_lt_o    <= '0;
      stat_sum_o   <= '0;
      stat_valid_o <= 1'b0;
    end else begin
      stat_valid_o <= (state == ST_CALC);
      if (state == ST_CALC) begin
        stat_gt_o  <= gt_cnt;
        stat_lt_o  <= lt_cnt;
        stat_sum_o <= sum;
      end
    end
  end
`else
  logic unused_lt;
  assign unused_lt = ^lt_cnt;
`endif

endmodule

// File: tb/tb_agc_servo.sv
// tb_agc_servo: directed windows with a scoreboard of expected updates.
// A monitor pops one entry per ce strobe and checks the apply that follows.
module tb_agc_servo;

  localparam int NB = 5;
  localparam int OB = 12;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst_n, en, valid, gt, lt;
  logic signed [NB-1:0] dat;

  logic [16:0] scale, scale_lo;
  logic signed [OB-1:0] offset, offset_lo;
  logic ce_s, ce_o, apply, busy;
  logic ce_s_lo, ce_o_lo, apply_lo, busy_lo;

`ifdef AGC_SERVO_STATS_EN
  logic [W:0] st_gt, st_lt, st_gt_lo, st_lt_lo;
  logic signed [NB+W-1:0] st_sum, st_sum_lo;
  logic st_v, st_v_lo;
`endif

  always #5 clk = ~clk;

  agc_servo #(
    .NBITS(NB), .OFFSET_BITS(OB), .WINDOW_LOG2(W),
    .GT_TARGET(32), .SCALE_SHIFT(4), .OFFSET_SHIFT(4),
    .SCALE_INIT(4096), .SCALE_MIN(64), .SETTLE(8)
  ) dut (
    .clk_i(clk), .aresetn_i(rst_n), .en_i(en),
    .valid_i(valid), .dat_i(dat), .gt_i(gt), .lt_i(lt),
    .scale_o(scale), .offset_o(offset),
    .ce_scale_o(ce_s), .ce_offset_o(ce_o),
    .apply_o(apply), .busy_o(busy)
`ifdef AGC_SERVO_STATS_EN
    , .stat_gt_o(st_gt), .stat_lt_o(st_lt),
    .stat_sum_o(st_sum), .stat_valid_o(st_v)
`endif
  );

  agc_servo #(
    .NBITS(NB), .OFFSET_BITS(OB), .WINDOW_LOG2(W),
    .GT_TARGET(32), .SCALE_SHIFT(4), .OFFSET_SHIFT(4),
    .SCALE_INIT(100), .SCALE_MIN(64), .SETTLE(8)
  ) dut_lo (
    .clk_i(clk), .aresetn_i(rst_n), .en_i(en),
    .valid_i(valid), .dat_i(dat), .gt_i(gt), .lt_i(lt),
    .scale_o(scale_lo), .offset_o(offset_lo),
    .ce_scale_o(ce_s_lo), .ce_offset_o(ce_o_lo),
    .apply_o(apply_lo), .busy_o(busy_lo)
`ifdef AGC_SERVO_STATS_EN
    , .stat_gt_o(st_gt_lo), .stat_lt_o(st_lt_lo),
    .stat_sum_o(st_sum_lo), .stat_valid_o(st_v_lo)
`endif
  );

  typedef struct {
    int sc; int of; int sc_lo;
    int gtc; int ltc; int sum; bit st;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  int m_sc, m_of, m_lo;

  task automatic chk(string name,
                     logic signed [63:0] act,
                     logic signed [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic bad(string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event not expected / not seen", name);
  endtask

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_init();
    exp_t e;
    m_sc = 4096; m_of = 0; m_lo = 100;
    e = '{sc: 4096, of: 0, sc_lo: 100,
          gtc: 0, ltc: 0, sum: 0, st: 1'b0};
    q.push_back(e);
  endtask

  task automatic wait_accum();
    for (int k = 0; k < 64; k++) begin
      if (!busy) return;
      valid = 1'b1; gt = 1'b0; lt = 1'b0; dat = '0;
      step();
    end
    bad("accum_timeout");
  endtask

  task automatic run_win(int ngt, int nlt, int dv,
                         int dsc, int dof, int esum);
    exp_t e;
    wait_accum();
    for (int i = 0; i < 256; i++) begin
      valid = 1'b1;
      gt = (i < ngt);
      lt = (i < nlt);
      if (dv == 0) dat = (i % 2 == 1) ? 5'sd5 : -5'sd5;
      else dat = NB'(dv);
      if (i == 255) begin
        m_sc = clampi(m_sc + dsc, 64, 131071);
        m_lo = clampi(m_lo + dsc, 64, 131071);
        m_of = clampi(m_of + dof, -2048, 2047);
        e = '{sc: m_sc, of: m_of, sc_lo: m_lo,
              gtc: ngt, ltc: nlt, sum: esum, st: 1'b1};
        q.push_back(e);
      end
      step();
    end
    valid = 1'b0; gt = 1'b0; lt = 1'b0;
  endtask

  task automatic wait_apply();
    for (int k = 0; k < 40; k++) begin
      if (apply) return;
      step();
    end
    bad("apply_timeout");
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    bit pend;
    int held;
    pend = 1'b0;
    held = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        continue;
      end
      if (pend) begin
        chk("apply", apply, 1);
        chk("apply_lo", apply_lo, 1);
        chk("apply_hold", scale, held);
        pend = 1'b0;
      end else if (apply) begin
        bad("unexpected_apply");
      end
      if (ce_s) begin
        if (q.size() == 0) begin
          bad("unexpected_ce");
        end else begin
          e = q.pop_front();
          chk("scale", scale, e.sc);
          chk("offset", offset, e.of);
          chk("ce_offset", ce_o, 1);
          chk("ce_lo", ce_s_lo, 1);
          chk("scale_lo", scale_lo, e.sc_lo);
`ifdef AGC_SERVO_STATS_EN
          chk("stat_valid", st_v, e.st);
          if (e.st) begin
            chk("stat_gt", st_gt, e.gtc);
            chk("stat_lt", st_lt, e.ltc);
            chk("stat_sum", st_sum, e.sum);
          end
`endif
          held = e.sc;
          pend = 1'b1;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    rst_n = 1'b0; en = 1'b1; valid = 1'b0;
    gt = 1'b0; lt = 1'b0; dat = '0;
    #23;
    chk("rst_scale", scale, 4096);
    chk("rst_offset", offset, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ce", ce_s, 0);
    chk("rst_apply", apply, 0);
    chk("rst_scale_lo", scale_lo, 100);
    @(negedge clk);
    push_init();
    rst_n = 1'b1;
    step();

    wait_apply();
    valid = 1'b0;
    step();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      valid = (k % 3 != 0);
      step();
      if (valid) n++;
      if (!busy) break;
    end
    chk("settle_count", n, 8);
    valid = 1'b0;

    run_win(32, 10, 0, 0, 0, 0);
    run_win(32, 10, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) run_win(128, 0, 0, -6, 0, 0);
    run_win(0, 256, -1, 2, 16, -256);
    for (int k = 0; k < 45; k++)
      run_win(128, 128, 3, -6, -48, 768);

    wait_accum();
    for (int i = 0; i < 100; i++) begin
      valid = 1'b1; gt = 1'b1; dat = 5'sd7;
      step();
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("en_low_busy", busy, 0);
    en = 1'b1;
    run_win(32, 0, 0, 0, 0, 0);

    wait_apply();
    valid = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_scale", scale, 4096);
    chk("mid_rst_offset", offset, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_scale_lo", scale_lo, 100);
    repeat (2) @(negedge clk);
    push_init();
    rst_n = 1'b1;
    step();
    run_win(32, 0, 0, 0, 0, 0);

    valid = 1'b0;
    repeat (30) step();
    chk("queue_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
